// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store data-memory master.
package lsu_pkg;

  // funct3 size/sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encoding
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_ACC0 = 2'd1;
  localparam lsu_state_t ST_ACC1 = 2'd2;
  localparam lsu_state_t ST_RESP = 2'd3;

  // Byte-lane mask for an access starting at lane 0
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Reserved encodings, plus unsigned variants on a store
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    f3_illegal = (f3 == 3'b011) || (f3[2] && f3[1]) || (f3[2] && we);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store window/mask build and load extract/extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [7:0]  o_mask,
  output logic [63:0] o_wwin,
  output logic [31:0] o_rdata
);

  logic [31:0] w_win;

  // 8-lane window spanning word A (low nibble) and A+4 (high nibble)
  assign o_mask = {4'b0000, size_mask(i_funct3)} << i_off;
  assign o_wwin = {32'h0, i_wdata} << {i_off, 3'b000};

  // Loaded bytes shifted down so the addressed byte lands in lane 0
  assign w_win = 32'({i_hi, i_lo} >> {i_off, 3'b000});

  // Truncate to size and extend
  always_comb begin
    o_rdata = 32'h0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_win[7]}}, w_win[7:0]};
      F3_H:    o_rdata = {{16{w_win[15]}}, w_win[15:0]};
      F3_W:    o_rdata = w_win;
      F3_BU:   o_rdata = {24'h0, w_win[7:0]};
      F3_HU:   o_rdata = {16'h0, w_win[15:0]};
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store initiator: one request at a time, split into up to two word
// accesses on the 4-bank data memory port.
module lsu_dmem_master
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  lsu_state_t  r_state;
  logic        r_we;
  logic        r_err;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_lo;
  logic [31:0] r_hi;

  logic [7:0]  w_mask;
  logic [63:0] w_wwin;
  logic [31:0] w_rdata;
  logic [31:0] w_wa;
  logic [31:0] w_wa_nxt;

  assign w_wa     = {r_addr[31:2], 2'b00};
  assign w_wa_nxt = w_wa + 32'd4;   // wraps past the top of the address space

  lsu_lane_align u_align (
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .i_wdata  (r_wdata),
    .i_lo     (r_lo),
    .i_hi     (r_hi),
    .o_mask   (w_mask),
    .o_wwin   (w_wwin),
    .o_rdata  (w_rdata)
  );

  // FSM and capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_lo    <= 32'h0;
      r_hi    <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_f3    <= req_funct3;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_err   <= f3_illegal(req_funct3, req_we);
          r_state <= f3_illegal(req_funct3, req_we) ? ST_RESP : ST_ACC0;
        end
        ST_ACC0: begin
          if (!r_we) r_lo <= drdata;
          r_state <= (|w_mask[7:4]) ? ST_ACC1 : ST_RESP;
        end
        ST_ACC1: begin
          if (!r_we) r_hi <= drdata;
          r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port and response outputs decoded from registered state only
  always_comb begin
    req_ready = (r_state == ST_IDLE);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    daddr     = 32'h0;
    dwdata    = 32'h0;
    dwe       = 4'b0000;
    case (r_state)
      ST_ACC0: begin
        daddr = w_wa;
        if (r_we) begin
          dwe    = w_mask[3:0];
          dwdata = w_wwin[31:0];
        end
      end
      ST_ACC1: begin
        daddr = w_wa_nxt;
        if (r_we) begin
          dwe    = w_mask[7:4];
          dwdata = w_wwin[63:32];
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_err || r_we) ? 32'h0 : w_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master: byte-level reference memory model,
// directed scenarios followed by randomized loads/stores.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  lsu_dmem_master dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  bmem [bit [31:0]];   // memory seen on the bus
  logic [7:0]  smem [bit [31:0]];   // reference memory
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          dwe_cnt = 0;

  function automatic logic [7:0] init_b(input bit [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] brd(input bit [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_b(a);
  endfunction

  function automatic logic [7:0] srd(input bit [31:0] a);
    return smem.exists(a) ? smem[a] : init_b(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: sample port just before the edge, write at the edge
  initial begin
    logic [31:0] s_a, s_d;
    logic [3:0]  s_we;
    drdata = 32'h0;
    forever begin
      @(negedge clk); #4;
      s_a = daddr; s_d = dwdata; s_we = dwe;
      drdata = {brd(s_a + 32'd3), brd(s_a + 32'd2), brd(s_a + 32'd1), brd(s_a)};
      @(posedge clk);
      if (s_we != 4'b0000) begin
        dwe_cnt++;
        for (int i = 0; i < 4; i++)
          if (s_we[i]) bmem[s_a + 32'(i)] = s_d[8*i +: 8];
      end
    end
  end

  // Monitor: pop expected response whenever the DUT presents one
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Issue one request; reference result from byte-level semantics
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit push);
    int g, sz, c;
    bit ill;
    logic [31:0] v;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = cyc;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ill = we ? !(f3 inside {3'b000, 3'b001, 3'b010})
             : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    v = 32'h0;
    if (!ill && !we) begin
      for (int i = 0; i < sz; i++) v |= 32'(srd(a + 32'(i))) << (8 * i);
      if (!f3[2] && sz == 1 && v[7])  v |= 32'hFFFF_FF00;
      if (!f3[2] && sz == 2 && v[15]) v |= 32'hFFFF_0000;
    end
    if (!ill && we && push)
      for (int i = 0; i < sz; i++) smem[a + 32'(i)] = wd[8*i +: 8];
    e.err   = ill;
    e.rdata = v;
    e.cyc   = ill ? c : ((32'(a[1:0]) + sz > 4) ? c + 2 : c + 1);
    if (push) sbq.push_back(e);
  endtask

  task automatic bus_chk(input string nm, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d);
    @(negedge clk);
    chk({nm, "_daddr"}, daddr, a);
    chk({nm, "_dwe"}, {28'h0, dwe}, {28'h0, m});
    chk({nm, "_dwdata"}, dwdata, d);
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    if (!req_ready) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int wc;
    bit [31:0] k;
    logic [31:0] a;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
    chk("rst_daddr", daddr, 32'h0);
    chk("rst_dwdata", dwdata, 32'h0);
    chk("rst_dwe", {28'h0, dwe}, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Aligned word store
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1);
    bus_chk("sw_acc0", 32'h100, 4'b1111, 32'hDEADBEEF);
    // Byte store into lane 3, then signed/unsigned byte loads
    issue(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 1'b1);
    bus_chk("sb_acc0", 32'h100, 4'b1000, 32'hA500_0000);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b1);
    // Split word store and reload
    issue(1'b1, 3'b010, 32'h1FE, 32'h1122_3344, 1'b1);
    bus_chk("split_acc0", 32'h1FC, 4'b1100, 32'h3344_0000);
    bus_chk("split_acc1", 32'h200, 4'b0011, 32'h0000_1122);
    issue(1'b0, 3'b010, 32'h1FE, 32'h0, 1'b1);
    // Halfword load wrapping the address space
    issue(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h80, 1'b1);
    issue(1'b1, 3'b000, 32'h0, 32'h7F, 1'b1);
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 1'b1);
    bus_chk("wrap_acc0", 32'hFFFF_FFFC, 4'b0000, 32'h0);
    bus_chk("wrap_acc1", 32'h0, 4'b0000, 32'h0);
    wait_idle();
    // Illegal encodings: no memory writes at all
    wc = dwe_cnt;
    issue(1'b0, 3'b011, 32'h104, 32'h0, 1'b1);
    issue(1'b1, 3'b100, 32'h104, 32'hFFFF_FFFF, 1'b1);
    issue(1'b1, 3'b111, 32'h105, 32'h1234_5678, 1'b1);
    wait_idle();
    chk("illegal_no_write", 32'(dwe_cnt), 32'(wc));

    // Reset during ACC1 of a split store: only the first word lands
    issue(1'b1, 3'b010, 32'h2FE, 32'hAABB_CCDD, 1'b0);
    @(negedge clk);             // ACC0
    @(negedge clk);             // ACC1, first word written
    #2 reset_n = 1'b0;
    #1;
    chk("abort_dwe", {28'h0, dwe}, 32'h0);
    chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    smem[32'h2FE] = 8'hDD;
    smem[32'h2FF] = 8'hCC;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'h0, req_ready}, 32'd1);

    // Randomized loads/stores, clustered to provoke overlap and wrap
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else                           a = 32'h400 + 32'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // Bus memory must match the reference byte for byte
    foreach (bmem[k]) chk("mem_bus", {24'h0, bmem[k]}, {24'h0, srd(k)});
    foreach (smem[k]) if (!bmem.exists(k)) chk("mem_ref", {24'h0, init_b(k)}, {24'h0, smem[k]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
# lsu_dmem_master

Load/store initiator that sits between the CPU execute stage and the data memory port. It accepts one load or store request at a time and drives `daddr`/`dwdata`/`dwe` to the word-organised, 4-bank data memory. Loads sample `drdata` and return the byte-selected, sign- or zero-extended result. Accesses that cross a word boundary are split into two word transactions.

## Interface
Parameters:
- none; data width is 32 and the memory port is byte-addressed and word-organised.

Ports:
- `clk` in 1: clock; all state changes on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit accepts a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: size/sign field. 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are valid for loads only.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse, with no backpressure.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: illegal funct3; qualified by `rsp_valid`.
- `daddr` out 32: word-aligned memory address, with bits [1:0] always 00.
- `dwdata` out 32: lane-aligned write data.
- `dwe` out 4: byte write mask; bit i enables byte lane i.
- `drdata` in 32: asynchronous memory read data.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- Handshake: a request is accepted when `req_valid && req_ready` at a posedge. Address, data, funct3 and we are captured; next state is ACC0, or RESP if funct3 is illegal.
- Offset and sizes: o = addr[1:0]. Size mask m is 0001 (B/BU), 0011 (H/HU) or 1111 (W). The 8-bit window mask M = m << o.
  - Low nibble of M applies to word A = {addr[31:2],00}.
  - High nibble of M applies to A+4, computed mod 2^32, so 0xFFFFFFFC wraps to 0x0.
- Store data: the 64-bit window {32'b0, wdata} << 8*o. The low half goes to A and the high half to A+4.
- ACC0:
  - Drive `daddr`=A.
  - For stores, drive `dwe` = M[3:0] and `dwdata` = the low half.
  - For loads, capture `drdata` into lo.
  - Next state is ACC1 if M[7:4]≠0, else RESP.
- ACC1:
  - Drive `daddr`=A+4.
  - For stores, drive `dwe` = M[7:4] and `dwdata` = the high half.
  - For loads, capture `drdata` into hi.
  - Next state is RESP.
- RESP:
  - `rsp_valid`=1.
  - For loads, `rsp_rdata` = ({hi,lo} >> 8*o) truncated to the size. B/H are sign-extended; BU/HU/W are zero-extended.
  - `rsp_rdata`=0 for stores.
  - Next state is IDLE.
- Illegal funct3 (011, 110, 111, or BU/HU with we=1): no memory access; RESP with `rsp_err`=1 and `rsp_rdata`=0.
- In IDLE and RESP: `daddr`=0, `dwdata`=0, `dwe`=0.

## Timing
- Reset (asynchronous, effective immediately):
  - State = IDLE and captured registers are cleared.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `daddr`=0, `dwdata`=0, `dwe`=0.
- Latency, counted in cycles from the accept edge:
  - Aligned access: ACC0 in cycle 1, `rsp_valid` in cycle 2, `req_ready` again in cycle 3. Throughput is 1 per 3 cycles.
  - Split access: one extra cycle, so `rsp_valid` in cycle 3.
  - Illegal request: `rsp_valid` in cycle 1.
- Memory port outputs are combinational from registered state only. `drdata` is sampled at the posedge ending ACC0/ACC1, and the memory writes at that same edge.
- A request held while `req_ready`=0 is ignored and must stay stable until accepted.
- Reset asserted mid-operation: immediate return to IDLE with `dwe`=0.
  - A split store interrupted after ACC0 leaves its first word written. This is documented behaviour, not an error.
  - No response is generated for the aborted request.

## Structure
- `lsu_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, and the size-mask function.
- One combinational sub-module, `lsu_lane_align`: store shift/mask generation and load extract/extend.
- The top level holds the FSM and capture registers.

## Test plan
- SW addr 0x100, data 0xDEADBEEF -> one ACC0 with `daddr`=0x100, `dwe`=1111, `dwdata`=0xDEADBEEF. `rsp_valid` in cycle 2 with `rsp_err`=0.
- SB 0x0000_00A5 to 0x103 -> `daddr`=0x100, `dwe`=1000, `dwdata`=0xA5000000. Then LB 0x103 -> `rsp_rdata`=0xFFFFFFA5, and LBU 0x103 -> 0x000000A5.
- SW 0x11223344 to 0x1FE (split) -> ACC0 `daddr`=0x1FC, `dwe`=1100, `dwdata`=0x33440000. ACC1 `daddr`=0x200, `dwe`=0011, `dwdata`=0x00001122. LW 0x1FE returns 0x11223344 in cycle 3.
- LH 0xFFFFFFFF -> accesses 0xFFFFFFFC then 0x00000000 (wrap). With memory bytes 0x80 at 0xFFFFFFFF and 0x7F at 0x0, `rsp_rdata`=0x00007F80.
- funct3=011 and SBU (we=1, funct3=100) -> `dwe` never nonzero. `rsp_valid`/`rsp_err`=1 in cycle 1 with `rsp_rdata`=0.
- Split store with `reset_n` pulled low during ACC1 -> `dwe`=0 immediately, no `rsp_valid`, `req_ready`=1 after release, and only the first word is modified.
